l1_dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache controller. It sits between the CPU's MEM stage and a multi-cycle off-chip data memory: the MEM-stage address, write data and read/write strobe come in, and read data goes back out. On a miss it raises a stall that freezes the pipeline while it evicts and refills the line over a request/acknowledge memory port.

---
 rtl/l1_dcache_if.sv | 34 +++
 rtl/l1_dcache_ctrl.sv | 123 ++++++++++++
 tb/tb_l1_dcache_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_dcache_if.sv
// L1 data cache bus bundle: CPU MEM-stage side plus the line memory port.
// slave = cache controller, master = pipeline/memory environment.
interface l1_dcache_if;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    input  mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_data_o,
    output hit_cnt_o, miss_cnt_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    output mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_data_o,
    input  hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller.
// Misses stall the pipeline while the line is evicted and refilled.
module l1_dcache_ctrl #(
  parameter int NUM_LINES = 16
) (
  input logic        clk_i,
  input logic        rst_i,
  l1_dcache_if.slave bus
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 27 - IW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;
  localparam logic [1:0] S_FILL  = 2'd3;

  logic [1:0]           state_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TW-1:0]        tag_q [NUM_LINES];
  logic [255:0]         data_q [NUM_LINES];
  logic [255:0]         fill_q;
  logic                 replay_q;
  logic [31:0]          hit_q;
  logic [31:0]          miss_q;

  logic [TW-1:0] tag;
  logic [IW-1:0] idx;
  logic [2:0]    word;
  logic          idle;
  logic          hit;
  logic          st_wr;
  logic          unused_addr;

  assign tag  = bus.cpu_addr_i[31:5+IW];
  assign idx  = bus.cpu_addr_i[4+IW:5];
  assign word = bus.cpu_addr_i[4:2];
  assign idle = state_q == S_IDLE;
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign st_wr = idle && bus.cpu_req_i && hit && bus.cpu_we_i;
  assign unused_addr = ^bus.cpu_addr_i[1:0];

  assign bus.hit_cnt_o  = hit_q;
  assign bus.miss_cnt_o = miss_q;

  always_comb begin
    bus.cpu_stall_o = rst_i && (!idle || (bus.cpu_req_i && !hit));
    bus.cpu_data_o  = '0;
    if (rst_i && idle && bus.cpu_req_i && hit)
      bus.cpu_data_o = data_q[idx][{word, 5'b0} +: 32];
    bus.mem_req_o  = 1'b0;
    bus.mem_we_o   = 1'b0;
    bus.mem_addr_o = '0;
    bus.mem_data_o = '0;
    unique case (state_q)
      S_WB: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_we_o   = 1'b1;
        bus.mem_addr_o = {tag_q[idx], idx, 5'b0};
        bus.mem_data_o = data_q[idx];
      end
      S_ALLOC: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = {bus.cpu_addr_i[31:5], 5'b0};
      end
      S_IDLE, S_FILL: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      replay_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          replay_q <= 1'b0;
          if (bus.cpu_req_i && hit) begin
            // The post-fill replay was already counted as a miss
            if (!replay_q) hit_q <= hit_q + 32'd1;
            if (bus.cpu_we_i) dirty_q[idx] <= 1'b1;
          end else if (bus.cpu_req_i) begin
            miss_q  <= miss_q + 32'd1;
            state_q <= (valid_q[idx] && dirty_q[idx]) ? S_WB : S_ALLOC;
          end
        end
        S_WB: begin
          if (bus.mem_ack_i) state_q <= S_ALLOC;
        end
        S_ALLOC: begin
          if (bus.mem_ack_i) state_q <= S_FILL;
        end
        S_FILL: begin
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
          replay_q     <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; writes are blocked while in reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (st_wr)
        data_q[idx][{word, 5'b0} +: 32] <= bus.cpu_data_i;
      if (state_q == S_ALLOC && bus.mem_ack_i)
        fill_q <= bus.mem_data_i;
      if (state_q == S_FILL) begin
        data_q[idx] <= fill_q;
        tag_q[idx]  <= tag;
      end
    end
  end
endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Self-checking bench for l1_dcache_ctrl: directed table, corner
// sequences and random traffic against a flat-memory reference.
module tb_l1_dcache_ctrl;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l1_dcache_if bus();

  l1_dcache_ctrl #(.NUM_LINES(16)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] bmem [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  logic [31:0] mtag [16];
  logic        mvalid [16];
  logic        mdirty [16];
  int          exp_hit;
  int          exp_miss;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          lw;
    int          la;
    int          stall;
    logic [31:0] rd;
    int          hits;
    int          misses;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] bget(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] rget(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    exp_hit  = 0;
    exp_miss = 0;
    refm = bmem;
  endtask

  // Called at posedge+1; returns at posedge+1 after the access retires
  task automatic access(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input int lw, input int la,
                        output int ns, output logic [31:0] rd);
    int          idx;
    logic [31:0] tg;
    logic        mhit;
    logic        exp_wb;
    logic [31:0] wb_addr;
    int          exp_ns;
    int          rc;
    int          wb_seen;
    int          lat;
    logic [31:0] f_addr;
    logic [255:0] f_data;
    logic [255:0] line;
    idx     = int'(a[4+IW:5]);
    tg      = a >> (5 + IW);
    mhit    = mvalid[idx] && mtag[idx] == tg;
    exp_wb  = !mhit && mvalid[idx] && mdirty[idx];
    wb_addr = (mtag[idx] << (5 + IW)) | (idx << 5);
    exp_ns  = mhit ? 0 : 2 + la + (exp_wb ? lw : 0);
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = a;
    bus.cpu_data_i = d;
    ns = 0;
    rc = 0;
    wb_seen = 0;
    f_addr = '0;
    f_data = '0;
    forever begin
      @(negedge clk);
      if (!bus.cpu_stall_o) break;
      ns++;
      if (bus.mem_req_o) begin
        rc++;
        if (rc == 1) begin
          f_addr = bus.mem_addr_o;
          f_data = bus.mem_data_o;
          if (exp_wb && wb_seen == 0) begin
            chk("wb we", bus.mem_we_o, 1'b1);
            chk("wb addr", bus.mem_addr_o, wb_addr);
          end else begin
            chk("alloc we", bus.mem_we_o, 1'b0);
            chk("alloc addr", bus.mem_addr_o, {a[31:5], 5'b0});
          end
        end else begin
          chk("req addr stable", bus.mem_addr_o, f_addr);
          chk("req data stable", bus.mem_data_o, f_data);
        end
        lat = bus.mem_we_o ? lw : la;
        if (rc >= lat) begin
          bus.mem_ack_i = 1'b1;
          if (bus.mem_we_o) begin
            wb_seen++;
            for (int k = 0; k < 8; k++)
              line[k*32 +: 32] = rget(bus.mem_addr_o + 32'(4 * k));
            chk("wb line", bus.mem_data_o, line);
            for (int k = 0; k < 8; k++)
              bmem[bus.mem_addr_o + 32'(4 * k)] = bus.mem_data_o[k*32 +: 32];
          end else begin
            for (int k = 0; k < 8; k++)
              line[k*32 +: 32] = bget(bus.mem_addr_o + 32'(4 * k));
            bus.mem_data_i = line;
          end
          rc = 0;
        end
      end else begin
        chk("idle mem bus zero",
            {bus.mem_we_o, bus.mem_addr_o} | {1'b0, 32'(|bus.mem_data_o)},
            33'd0);
      end
      if (ns > 100) begin
        chk("stall timeout", 1'b1, 1'b0);
        break;
      end
      @(posedge clk);
      #1;
      bus.mem_ack_i = 1'b0;
    end
    rd = bus.cpu_data_o;
    chk("stall cycles", ns, exp_ns);
    chk("wb count", wb_seen, exp_wb ? 1 : 0);
    if (!we) chk("load data", rd, rget(a));
    if (mhit) exp_hit++;
    else begin
      exp_miss++;
      mdirty[idx] = 1'b0;
    end
    mvalid[idx] = 1'b1;
    mtag[idx]   = tg;
    if (we) begin
      mdirty[idx] = 1'b1;
      refm[a]     = d;
    end
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b0;
    chk("hit cnt", bus.hit_cnt_o, exp_hit);
    chk("miss cnt", bus.miss_cnt_o, exp_miss);
  endtask

  initial begin
    int          ns;
    logic [31:0] rd;
    logic        found;
    logic [31:0] a;

    tbl[0] = '{1'b0, 32'h44,  32'h0,        1, 3,  5, 32'h1001,     0, 1};
    tbl[1] = '{1'b1, 32'h44,  32'hDEADBEEF, 1, 1,  0, 32'h0,        1, 1};
    tbl[2] = '{1'b0, 32'h44,  32'h0,        1, 1,  0, 32'hDEADBEEF, 2, 1};
    tbl[3] = '{1'b0, 32'h244, 32'h0,        2, 2,  6, 32'h5A5A0244, 2, 2};
    tbl[4] = '{1'b0, 32'h44,  32'h0,        1, 10, 12, 32'hDEADBEEF, 2, 3};
    tbl[5] = '{1'b1, 32'h100, 32'hCAFEF00D, 1, 2,  4, 32'h0,        2, 4};
    tbl[6] = '{1'b0, 32'h100, 32'h0,        1, 1,  0, 32'hCAFEF00D, 3, 4};
    tbl[7] = '{1'b0, 32'h300, 32'h0,        3, 1,  6, 32'h5A5A0300, 3, 5};

    rst_n          = 1'b0;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h44;
    bus.cpu_data_i = '0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    @(negedge clk);
    chk("reset stall", bus.cpu_stall_o, 1'b0);
    chk("reset data", bus.cpu_data_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.cpu_req_i = 1'b0;
    @(negedge clk);
    chk("reset mem_req", bus.mem_req_o, 1'b0);
    chk("reset mem_addr", bus.mem_addr_o, 32'h0);
    chk("reset hit cnt", bus.hit_cnt_o, 32'h0);
    chk("reset miss cnt", bus.miss_cnt_o, 32'h0);
    chk("reset idle stall", bus.cpu_stall_o, 1'b0);
    for (int k = 0; k < 8; k++) bmem[32'h40 + 32'(4 * k)] = 32'h1000 + 32'(k);
    model_reset();
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].lw, tbl[i].la, ns, rd);
      chk($sformatf("tbl%0d stall", i), ns, tbl[i].stall);
      if (!tbl[i].we) chk($sformatf("tbl%0d data", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d hits", i), bus.hit_cnt_o, tbl[i].hits);
      chk($sformatf("tbl%0d misses", i), bus.miss_cnt_o, tbl[i].misses);
    end

    // Spurious ack while idle must be ignored
    bus.mem_ack_i = 1'b1;
    @(negedge clk);
    chk("spur mem_req", bus.mem_req_o, 1'b0);
    chk("spur stall", bus.cpu_stall_o, 1'b0);
    @(posedge clk);
    #1;
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    chk("spur miss cnt", bus.miss_cnt_o, exp_miss);
    chk("spur mem_req after", bus.mem_req_o, 1'b0);
    @(posedge clk);
    #1;
    access(1'b0, 32'h300, 32'h0, 1, 1, ns, rd);
    chk("spur then hit stall", ns, 0);

    // Reset while in WRITEBACK
    access(1'b1, 32'h44, 32'h11112222, 1, 2, ns, rd);
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h244;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = bus.mem_req_o && bus.mem_we_o;
    end
    chk("reached writeback", found, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.cpu_req_i = 1'b0;
    @(negedge clk);
    chk("rst wb mem_req", bus.mem_req_o, 1'b0);
    chk("rst wb hit cnt", bus.hit_cnt_o, 32'h0);
    chk("rst wb miss cnt", bus.miss_cnt_o, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    access(1'b0, 32'h44, 32'h0, 1, 2, ns, rd);
    chk("post reset miss", bus.miss_cnt_o, 32'h1);
    chk("post reset data", rd, 32'hDEADBEEF);

    for (int i = 0; i < 400; i++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5) |
          (32'($urandom_range(0, 7)) << 2);
      access(1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(1, 4), $urandom_range(1, 4), ns, rd);
      if ($urandom_range(0, 7) == 0) begin
        bus.mem_ack_i = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ack_i = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
